// File: rtl/fs_serial_if.sv
// Valid/ready operand and result bundle for the bit-serial subtractor.
// The master modport is the side that drives operands and accepts results.
interface fs_serial_if #(parameter int W = 4);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         b_out;

    modport master (
        output in_valid, a, b, b_in, out_ready,
        input  in_ready, out_valid, d, b_out
    );

    modport slave (
        input  in_valid, a, b, b_in, out_ready,
        output in_ready, out_valid, d, b_out
    );
endinterface

// File: rtl/fs_serial.sv
// Bit-serial W-bit subtractor d = a - b - b_in, LSB first, one borrow flop.
// Optional SUB_SAT_EN: clamp d to zero when the final borrow is set.
module fs_serial #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    fs_serial_if.slave   bus
);
    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // BUSY  | one bit processed per clock, W clocks total
    // DONE  | result presented, held until out_ready
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = $clog2(W) + 1;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  r_sh;
    logic [W-1:0]  r_nxt;
    logic [W-1:0]  d_q;
    logic          br;
    logic          br_nxt;
    logic          dbit;
    logic          b_out_q;
    logic          last_bit;
    logic [CW-1:0] cnt;

    assign dbit     = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign last_bit = (cnt == CW'(W - 1));

    // Difference bits enter from the MSB side so the LSB lands at bit 0 after W shifts.
    always_comb begin
        r_nxt        = r_sh >> 1;
        r_nxt[W-1]   = dbit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            d_q     <= '0;
            b_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh <= bus.a;
                        b_sh <= bus.b;
                        r_sh <= '0;
                        br   <= bus.b_in;
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_nxt;
                    br   <= br_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        b_out_q <= br_nxt;
`ifdef SUB_SAT_EN
                        d_q     <= br_nxt ? '0 : r_nxt;
`else
                        d_q     <= r_nxt;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.d     = d_q;
    assign bus.b_out = b_out_q;
endmodule

// File: tb/tb_fs_serial.sv
// Directed and randomised checks of fs_serial at W=4, including backpressure,
// mid-operation reset and back-to-back throughput.
module tb_fs_serial;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_d;
        logic         exp_bout;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    fs_serial_if #(.W(W)) bus ();

    fs_serial #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sat(input logic [W-1:0] dv, input logic bo);
`ifdef SUB_SAT_EN
        return bo ? '0 : dv;
`else
        return dv;
`endif
    endfunction

    // Launch one op from IDLE and wait for DONE; caller is at #1 after an edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                            output int lat);
        bus.a = av;
        bus.b = bv;
        bus.b_in = bi;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = ~av;
        bus.b = ~bv;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    vec_t vecs[9];
    int   lat;
    int   n;
    int   prev_acc;
    logic [W-1:0] ra, rb, na, nb;
    logic         rbin, nbin;
    logic [W:0]   ref_diff;

    initial begin
        vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
        vecs[1] = '{4'd3,  4'd9,  1'b0, 4'd10, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
        vecs[4] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};
        vecs[5] = '{4'd7,  4'd7,  1'b1, 4'd15, 1'b1};
        vecs[6] = '{4'd8,  4'd1,  1'b1, 4'd6,  1'b0};
        vecs[7] = '{4'd0,  4'd15, 1'b1, 4'd0,  1'b1};
        vecs[8] = '{4'd5,  4'd4,  1'b1, 4'd0,  1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.b_in      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset in_ready", bus.in_ready, 1);
        check("reset out_valid", bus.out_valid, 0);
        check("reset d", bus.d, 0);
        check("reset b_out", bus.b_out, 0);

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            check($sformatf("vec%0d latency", i), lat, W);
            check($sformatf("vec%0d d", i), bus.d, sat(vecs[i].exp_d, vecs[i].exp_bout));
            check($sformatf("vec%0d b_out", i), bus.b_out, vecs[i].exp_bout);
            release_result();
            check($sformatf("vec%0d back to idle", i), bus.in_ready, 1);
        end

        // Backpressure: hold result for 5 cycles, pulse in_valid meanwhile.
        start_op(4'd9, 4'd3, 1'b0, lat);
        for (int k = 0; k < 5; k++) begin
            check("bp out_valid", bus.out_valid, 1);
            check("bp in_ready", bus.in_ready, 0);
            check("bp d", bus.d, 6);
            check("bp b_out", bus.b_out, 0);
            if (k == 2) begin
                bus.a = 4'd1;
                bus.b = 4'd2;
                bus.b_in = 1'b1;
                bus.in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
        release_result();
        check("bp released out_valid", bus.out_valid, 0);
        for (int k = 0; k < 3; k++) begin
            check("bp no capture in_ready", bus.in_ready, 1);
            @(posedge clk);
            #1;
        end
        check("bp d retained", bus.d, 6);

        // Reset two cycles into BUSY aborts the op.
        bus.a = 4'd9;
        bus.b = 4'd3;
        bus.b_in = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort in_ready", bus.in_ready, 1);
        check("abort out_valid", bus.out_valid, 0);
        check("abort d", bus.d, 0);
        check("abort b_out", bus.b_out, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("abort no result", bus.out_valid, 0);
        end
        start_op(4'd12, 4'd5, 1'b0, lat);
        check("post-abort latency", lat, W);
        check("post-abort d", bus.d, 7);
        check("post-abort b_out", bus.b_out, 0);
        release_result();

        // Back-to-back with in_valid and out_ready tied high.
        na = 4'($urandom_range(0, 15));
        nb = 4'($urandom_range(0, 15));
        nbin = 1'($urandom_range(0, 1));
        bus.a = na;
        bus.b = nb;
        bus.b_in = nbin;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 20) begin
                check("rand accept timeout", n, 0);
                break;
            end
            ra = na;
            rb = nb;
            rbin = nbin;
            @(posedge clk);
            #1;
            if (i > 0) check("rand accept interval", cyc - prev_acc, W + 2);
            prev_acc = cyc;
            na = 4'($urandom_range(0, 15));
            nb = 4'($urandom_range(0, 15));
            nbin = 1'($urandom_range(0, 1));
            bus.a = na;
            bus.b = nb;
            bus.b_in = nbin;
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            ref_diff = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            check("rand latency", n, W);
            check("rand d", bus.d, sat(ref_diff[W-1:0], ref_diff[W]));
            check("rand b_out", bus.b_out, ref_diff[W]);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
